// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Arbitrates a fetch port (i_*) and a load/store port (d_*) onto one shared
// single-port memory. Data requests win ties, except that an instruction
// request that has watched STARVE_LIMIT consecutive data grants wins the
// next tie. Every transfer is followed by one idle turnaround cycle (the
// cycle in which the x_ack pulse is high). No grant is made in that cycle.
//
// Ports
//   clock, reset              : clock; synchronous active-high reset
//   i_req, i_addr             : fetch request (held until i_ack), byte address
//   i_ack, i_rdata            : one-cycle completion pulse, fetched word
//   d_req, d_we, d_addr,
//   d_wdata                   : load/store request (held until d_ack)
//   d_ack, d_rdata            : one-cycle completion pulse, load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                 : registered request to memory (word address)
//   mem_ack, mem_rdata        : memory completion and read data
//   i_stall, d_stall          : pipeline freeze, x_req & ~x_ack
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        i_stall,
   output logic        d_stall
);

   localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [29:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic            i_ack_q, i_ack_d;
   logic            d_ack_q, d_ack_d;
   logic [31:0]     i_rdata_q, i_rdata_d;
   logic [31:0]     d_rdata_q, d_rdata_d;

   logic turnaround;
   logic grant_d;
   logic grant_i;

   // Byte-offset bits are don't-care for word accesses.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

   always_comb begin
      // An ack pulse marks the turnaround cycle; a request still high then
      // is the one just served, so nobody is granted.
      turnaround = i_ack_q | d_ack_q;
      grant_d    = (state_q == StIdle) & ~turnaround & d_req &
                   (~i_req | (starve_cnt_q != CntMax));
      grant_i    = (state_q == StIdle) & ~turnaround & i_req & ~grant_d;
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;

      unique case (state_q)
         StIdle: begin
            // mem_ack is ignored here; it can only be stale.
            if (grant_d) begin
               state_d     = StBusyD;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr[31:2];
               mem_wdata_d = d_wdata;
               if (i_req && (starve_cnt_q != CntMax)) begin
                  starve_cnt_d = starve_cnt_q + CntW'(1);
               end
            end else if (grant_i) begin
               state_d      = StBusyI;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = i_addr[31:2];
               mem_wdata_d  = 32'h0;
               starve_cnt_d = '0;
            end
         end
         StBusyI: begin
            if (mem_ack) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = mem_rdata;
            end
         end
         StBusyD: begin
            if (mem_ack) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               d_ack_d   = 1'b1;
               // Stores leave the load-data register untouched.
               if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         starve_cnt_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 30'h0;
         mem_wdata_q  <= 32'h0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= 32'h0;
         d_rdata_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_stall   = i_req & ~i_ack_q;
   assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: maximum consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clock, input, 1: sole clock; all state changes on posedge clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_req, input, 1: fetch-stage read request; held until i_ack.
REQ-005 SHALL have port i_addr, input, 32: fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port i_ack, output, 1: one-cycle pulse; i_rdata valid this cycle.
REQ-007 SHALL have port i_rdata, output, 32: fetched instruction word.
REQ-008 SHALL have port d_req, input, 1: MEM-stage request; held until d_ack.
REQ-009 SHALL have port d_we, input, 1: 1 = store (SW), 0 = load (LW).
REQ-010 SHALL have port d_addr, input, 32: data byte address; bits [1:0] ignored.
REQ-011 SHALL have port d_wdata, input, 32: store data.
REQ-012 SHALL have port d_ack, output, 1: one-cycle pulse; d_rdata valid this cycle on loads.
REQ-013 SHALL have port d_rdata, output, 32: load data.
REQ-014 SHALL have port mem_req, output, 1: request to the shared single-port memory.
REQ-015 SHALL have port mem_we, output, 1: write enable to memory.
REQ-016 SHALL have port mem_addr, output, 30: word address (byte address >> 2).
REQ-017 SHALL have port mem_wdata, output, 32: write data to memory.
REQ-018 SHALL have port mem_ack, input, 1: memory completion; latency of 1..N cycles after mem_req rises.
REQ-019 SHALL have port mem_rdata, input, 32: read data, valid when mem_ack=1.
REQ-020 SHALL have port i_stall, output, 1: i_req & ~i_ack (combinational), for the fetch-stage freeze.
REQ-021 SHALL have port d_stall, output, 1: d_req & ~d_ack (combinational), for the MEM-stage freeze.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-023 SHALL, in IDLE with any request, latch winner's address[31:2], we (0 for fetch) and wdata into mem_* registers and enter BUSY_I or BUSY_D next cycle.
REQ-024 SHALL hold mem_req=1 throughout BUSY_I/BUSY_D, with mem_addr/mem_we/mem_wdata stable, and mem_req=0 in IDLE.
REQ-025 SHALL, on mem_ack in BUSY_x, register mem_rdata into x_rdata, pulse x_ack for exactly the next cycle, and return to IDLE.
REQ-026 SHALL make minimum request-to-ack latency 3 cycles (grant, mem_ack same cycle as first mem_req, ack pulse); the IDLE cycle after each transfer is a mandatory turnaround.
REQ-027 SHALL not re-grant a requester in the cycle its x_ack is high (request still asserted that cycle is not a new request).
REQ-028 SHALL, when both request in IDLE, grant data unless starve_cnt == STARVE_LIMIT, in which case grant instruction.
REQ-029 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each data grant with i_req pending, and clear it on any instruction grant.
REQ-030 SHALL leave d_rdata unchanged on store completion; d_ack still pulses.
REQ-031 SHALL ignore mem_ack while in IDLE.
REQ-032 SHALL hold i_rdata/d_rdata between acks.

Reset
REQ-033 SHALL, on reset=1 at posedge, force state IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
REQ-034 SHALL, on reset mid-transfer, abandon the transfer: no x_ack pulse, and a mem_ack arriving after reset is ignored.
REQ-035 SHALL accept new requests in the first cycle after reset deasserts.

Verification
REQ-036 SHALL cover: i_req, i_addr=0x0000_0010, mem_ack one cycle after mem_req with rdata 0x8C01_0004 -> mem_addr=0x4, mem_we=0, i_ack pulse, i_rdata=0x8C01_0004.
REQ-037 SHALL cover: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> mem_addr=0x40, mem_we=1, mem_wdata=0xDEAD_BEEF, d_ack pulse, d_rdata unchanged.
REQ-038 SHALL cover: i_req and d_req rising same cycle -> data granted first, instruction granted in the IDLE following d_ack.
REQ-039 SHALL cover: i_req held, d_req re-asserted continuously, STARVE_LIMIT=3 -> exactly 3 data grants, then instruction grant, starve_cnt back to 0.
REQ-040 SHALL cover: reset asserted in BUSY_D before mem_ack, mem_ack one cycle later -> no d_ack, mem_req=0, state IDLE.
REQ-041 SHALL cover: mem_ack pulsed in IDLE with no requests -> no ack outputs, rdata registers unchanged.
